// File: rtl/window_gen_if.sv
// Stream interface for window_gen: pixel input handshake and window output handshake.
// With WINDOW_GEN_LAST_EN defined, an extra win_last flag travels with each window.
interface window_gen_if #(
  parameter int unsigned F           = 3,
  parameter int unsigned indatawidth = 8
);

  logic                           pix_valid;
  logic [indatawidth-1:0]         pix_data;
  logic                           pix_ready;
  logic                           win_valid;
  logic [F*F*indatawidth-1:0]     win_data;
  logic                           win_ready;
`ifdef WINDOW_GEN_LAST_EN
  logic                           win_last;
`endif

`ifdef WINDOW_GEN_LAST_EN
  // Producer of pixels / consumer of windows
  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, win_last
  );

  // The window generator itself
  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, win_last
  );
`else
  // Producer of pixels / consumer of windows
  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data
  );

  // The window generator itself
  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data
  );
`endif

endinterface

// File: rtl/window_gen.sv
// Sliding FxF window generator over an NxN raster-order image, stride 1, no padding.
// F-1 line buffers hold the previous image rows; an FxF register array holds the
// current window, which shifts left by one column on every accepted pixel.
// Optional feature: define WINDOW_GEN_LAST_EN to add win_last, flagging the final
// window of each frame.
module window_gen #(
  parameter int unsigned N           = 5,
  parameter int unsigned F           = 3,
  parameter int unsigned indatawidth = 8
) (
  input  logic       clk,
  input  logic       rst,
  window_gen_if.slave bus
);

  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned W    = indatawidth;
  localparam int unsigned WinW = F * F * W;

  localparam logic [CW-1:0] LastIdx     = CW'(N - 1);
  localparam logic [CW-1:0] FillLastRow = CW'(F - 2);
  localparam logic [CW-1:0] WinStart    = CW'(F - 1);

  // FILL: first F-1 rows, nothing to emit yet. RUN: windows being produced.
  // DONE: whole frame accepted, waiting for the final window to leave.
  localparam logic [1:0] StFill = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;

  // line_q[k] holds image row (current_row - (F-1) + k); not reset, always refilled
  // during FILL before any window can be built from it.
  logic [W-1:0]  line_q    [F-1][N];
  logic [W-1:0]  win_q     [F][F];
  logic [W-1:0]  win_shift [F][F];
  logic [W-1:0]  new_col   [F];
  logic [WinW-1:0] win_flat;

  logic            out_valid_q;
  logic [WinW-1:0] out_data_q;
  logic            out_last_q;

  logic pix_ready;
  logic pix_fire;
  logic win_fire;
  logic at_last_col;
  logic at_last_pix;
  logic win_load;

  // Input acceptance depends on the state and on whether the output slot frees up.
  always_comb begin
    pix_ready = 1'b0;
    case (state_q)
      StFill:  pix_ready = 1'b1;
      StRun:   pix_ready = !out_valid_q || bus.win_ready;
      default: pix_ready = 1'b0;
    endcase
  end

  assign pix_fire    = bus.pix_valid && pix_ready;
  assign win_fire    = out_valid_q && bus.win_ready;
  assign at_last_col = (col_q == LastIdx);
  assign at_last_pix = at_last_col && (row_q == LastIdx);
  assign win_load    = pix_fire && (row_q >= WinStart) && (col_q >= WinStart);

  // Incoming column: older rows from the line buffers, newest row is the pixel itself.
  always_comb begin
    for (int k = 0; k < F; k++) begin
      new_col[k] = '0;
    end
    for (int k = 0; k < F - 1; k++) begin
      new_col[k] = line_q[k][col_q];
    end
    new_col[F-1] = bus.pix_data;
  end

  // Window contents after shifting left by one column and appending new_col.
  always_comb begin
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        win_shift[r][c] = '0;
      end
      for (int c = 0; c < F - 1; c++) begin
        win_shift[r][c] = win_q[r][c+1];
      end
      win_shift[r][F-1] = new_col[r];
    end
  end

  // Flatten the shifted window: element (r,c) lands at slice r*F+c.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        win_flat[(r*F+c)*W +: W] = win_shift[r][c];
      end
    end
  end

  // Next-state and position counters; counters only move on an accepted pixel.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;

    if (pix_fire) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = (row_q == LastIdx) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      StFill: begin
        if (pix_fire && at_last_col && (row_q == FillLastRow)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (pix_fire && at_last_pix) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (win_fire) begin
          state_d = StFill;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: begin
        state_d = StFill;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Line buffers rotate one row up at the current column on every accepted pixel.
  always_ff @(posedge clk) begin
    if (pix_fire) begin
      for (int k = 0; k < F - 1; k++) begin
        line_q[k][col_q] <= new_col[k+1];
      end
    end
  end

  // Window register array shifts on every accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (pix_fire) begin
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F; c++) begin
          win_q[r][c] <= win_shift[r][c];
        end
      end
    end
  end

  // Output slot: loads a complete window, holds under backpressure, clears on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (win_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= win_flat;
      out_last_q  <= at_last_pix;
    end else if (win_fire) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.win_valid = out_valid_q;
  assign bus.win_data  = out_data_q;

`ifdef WINDOW_GEN_LAST_EN
  assign bus.win_last = out_last_q;
`else
  logic unused_last;
  assign unused_last = out_last_q;
`endif

endmodule
